// File: rtl/stack_cpu_controller.sv
// Multi-cycle control FSM for the 8-bit stack CPU: sequences fetch/decode/execute,
// tracks operand-stack depth and latches a sticky fault on under/overflow.
module stack_cpu_controller #(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         opcode,
  input  logic               zero,
  output logic               busy,
  output logic               fault,
  output logic [DEPTH_W-1:0] depth,
  output logic               pcWrite,
  output logic               pcSrc,
  output logic               iOrD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               mdrWrite,
  output logic               stPush,
  output logic               stPop,
  output logic               stSrc,
  output logic               aLd,
  output logic               bLd,
  output logic [1:0]         aluOp
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_POP_A,
    S_POP_B,
    S_ALU_WB,
    S_MEM_RD,
    S_PUSH_WB,
    S_POP_ST,
    S_MEM_WR,
    S_JUMP,
    S_FAULT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_PUSH = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_JZ   = 3'd7;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

  state_t             state_reg;
  state_t             state_next;
  logic [DEPTH_W-1:0] depth_reg;
  logic               decode_fault;

  assign depth = depth_reg;

  // Stack occupancy needed by each opcode, checked before any strobe is issued.
  always_comb begin
    decode_fault = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND: decode_fault = (depth_reg < DEPTH_TWO);
      OP_NOT, OP_POP, OP_JZ:  decode_fault = (depth_reg == '0);
      OP_PUSH:                decode_fault = (depth_reg == DEPTH_FULL);
      default:                decode_fault = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    state_next = start ? S_FETCH : S_IDLE;
      S_FETCH:   state_next = S_DECODE;
      S_DECODE: begin
        if (decode_fault) begin
          state_next = S_FAULT;
        end else begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_NOT: state_next = S_POP_A;
            OP_PUSH: state_next = S_MEM_RD;
            OP_POP:  state_next = S_POP_ST;
            OP_JMP:  state_next = S_JUMP;
            OP_JZ:   state_next = zero ? S_JUMP : S_FETCH;
            default: state_next = S_FETCH;
          endcase
        end
      end
      S_POP_A:   state_next = (opcode == OP_NOT) ? S_ALU_WB : S_POP_B;
      S_POP_B:   state_next = S_ALU_WB;
      S_ALU_WB:  state_next = S_FETCH;
      S_MEM_RD:  state_next = S_PUSH_WB;
      S_PUSH_WB: state_next = S_FETCH;
      S_POP_ST:  state_next = S_MEM_WR;
      S_MEM_WR:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      S_FAULT:   state_next = S_FAULT;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      depth_reg <= '0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      pcWrite   <= 1'b0;
      pcSrc     <= 1'b0;
      iOrD      <= 1'b0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      irWrite   <= 1'b0;
      mdrWrite  <= 1'b0;
      stPush    <= 1'b0;
      stPop     <= 1'b0;
      stSrc     <= 1'b0;
      aLd       <= 1'b0;
      bLd       <= 1'b0;
      aluOp     <= 2'b00;
    end else begin
      state_reg <= state_next;

      if (stPush) begin
        depth_reg <= depth_reg + 1'b1;
      end else if (stPop) begin
        depth_reg <= depth_reg - 1'b1;
      end

      busy     <= (state_next != S_IDLE) && (state_next != S_FAULT);
      fault    <= (state_next == S_FAULT);
      pcWrite  <= 1'b0;
      pcSrc    <= 1'b0;
      iOrD     <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      irWrite  <= 1'b0;
      mdrWrite <= 1'b0;
      stPush   <= 1'b0;
      stPop    <= 1'b0;
      stSrc    <= 1'b0;
      aLd      <= 1'b0;
      bLd      <= 1'b0;
      aluOp    <= 2'b00;

      case (state_next)
        S_FETCH: begin
          memRead <= 1'b1;
          irWrite <= 1'b1;
          pcWrite <= 1'b1;
        end
        S_POP_A: begin
          stPop <= 1'b1;
          aLd   <= 1'b1;
        end
        S_POP_B: begin
          stPop <= 1'b1;
          bLd   <= 1'b1;
        end
        S_ALU_WB: begin
          aluOp  <= opcode[1:0];
          stSrc  <= 1'b1;
          stPush <= 1'b1;
        end
        S_MEM_RD: begin
          memRead  <= 1'b1;
          iOrD     <= 1'b1;
          mdrWrite <= 1'b1;
        end
        S_PUSH_WB: stPush <= 1'b1;
        S_POP_ST: begin
          stPop <= 1'b1;
          aLd   <= 1'b1;
        end
        S_MEM_WR: begin
          memWrite <= 1'b1;
          iOrD     <= 1'b1;
        end
        S_JUMP: begin
          pcWrite <= 1'b1;
          pcSrc   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Bench for stack_cpu_controller: per-instruction expected output sequences are
// planned from opcode/depth/zero and compared against the DUT every cycle.
module tb_stack_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       busy, fault;
  logic [3:0] depth;
  logic       pcWrite, pcSrc, iOrD, memRead, memWrite, irWrite, mdrWrite;
  logic       stPush, stPop, stSrc, aLd, bLd;
  logic [1:0] aluOp;

  stack_cpu_controller #(.STACK_DEPTH(8), .DEPTH_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
    .busy(busy), .fault(fault), .depth(depth),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .iOrD(iOrD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .mdrWrite(mdrWrite),
    .stPush(stPush), .stPop(stPop), .stSrc(stSrc), .aLd(aLd), .bLd(bLd),
    .aluOp(aluOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       fault;
    logic [3:0] depth;
    logic       pcWrite;
    logic       pcSrc;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       mdrWrite;
    logic       stPush;
    logic       stPop;
    logic       stSrc;
    logic       aLd;
    logic       bLd;
    logic [1:0] aluOp;
  } ov_t;

  ov_t exp_q[$];
  ov_t plan_q[$];
  int  checks = 0;
  int  errors = 0;
  int  mdepth = 0;
  bit  mfault = 1'b0;
  bit  midle  = 1'b1;

  function automatic ov_t busy_vec();
    ov_t v;
    v = '0;
    v.busy  = 1'b1;
    v.depth = mdepth[3:0];
    return v;
  endfunction

  function automatic ov_t fault_vec();
    ov_t v;
    v = '0;
    v.fault = 1'b1;
    v.depth = mdepth[3:0];
    return v;
  endfunction

  function automatic bit faults(input logic [2:0] op);
    int need;
    need = (op <= 3'd2) ? 2 : ((op == 3'd3 || op == 3'd5 || op == 3'd7) ? 1 : 0);
    return (mdepth < need) || (op == 3'd4 && mdepth == 8);
  endfunction

  // Expected output vector for each cycle of one instruction, FETCH onward.
  task automatic plan_instr(input logic [2:0] op, input logic z);
    ov_t v;
    plan_q.delete();
    v = busy_vec(); v.memRead = 1; v.irWrite = 1; v.pcWrite = 1; plan_q.push_back(v);
    v = busy_vec(); plan_q.push_back(v);
    if (faults(op)) begin
      mfault = 1'b1;
      plan_q.push_back(fault_vec());
      return;
    end
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        v = busy_vec(); v.stPop = 1; v.aLd = 1; plan_q.push_back(v); mdepth--;
        if (op != 3'd3) begin
          v = busy_vec(); v.stPop = 1; v.bLd = 1; plan_q.push_back(v); mdepth--;
        end
        v = busy_vec(); v.aluOp = op[1:0]; v.stSrc = 1; v.stPush = 1; plan_q.push_back(v); mdepth++;
      end
      3'd4: begin
        v = busy_vec(); v.memRead = 1; v.iOrD = 1; v.mdrWrite = 1; plan_q.push_back(v);
        v = busy_vec(); v.stPush = 1; plan_q.push_back(v); mdepth++;
      end
      3'd5: begin
        v = busy_vec(); v.stPop = 1; v.aLd = 1; plan_q.push_back(v); mdepth--;
        v = busy_vec(); v.memWrite = 1; v.iOrD = 1; plan_q.push_back(v);
      end
      default: begin
        if (op == 3'd6 || z) begin
          v = busy_vec(); v.pcWrite = 1; v.pcSrc = 1; plan_q.push_back(v);
        end
      end
    endcase
  endtask

  task automatic tick(input ov_t v);
    @(posedge clk);
    #1;
    exp_q.push_back(v);
  endtask

  task automatic lit(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic do_reset(input int n);
    ov_t zv;
    zv = '0;
    rst = 1'b1;
    start = 1'b1;
    for (int i = 0; i < n; i++) tick(zv);
    rst = 1'b0;
    mdepth = 0;
    mfault = 1'b0;
    midle = 1'b1;
    $display("reset %0d cycles", n);
  endtask

  task automatic idle(input int n);
    ov_t zv;
    zv = '0;
    start = 1'b0;
    for (int i = 0; i < n; i++) tick(zv);
  endtask

  task automatic fault_hold(input int n);
    for (int i = 0; i < n; i++) begin
      start = ~start;
      tick(fault_vec());
    end
  endtask

  task automatic exec(input logic [2:0] op, input logic z, input int rst_after, output int ncyc);
    ov_t zv;
    zv = '0;
    plan_instr(op, z);
    ncyc = plan_q.size();
    if (midle) start = 1'b1;
    for (int i = 0; i < plan_q.size(); i++) begin
      tick(plan_q[i]);
      midle = 1'b0;
      start = 1'($urandom_range(0, 1));
      if (i == 0) begin
        opcode = op;
        zero = z;
      end
      if (i == rst_after) begin
        rst = 1'b1;
        mdepth = 0;
        mfault = 1'b0;
        tick(zv);
        rst = 1'b0;
        start = 1'b0;
        midle = 1'b1;
        ncyc = i + 1;
        break;
      end
    end
    $display("instr op=%0d zero=%0d cycles=%0d depth_after=%0d fault=%0d", op, z, ncyc, mdepth, mfault);
  endtask

  always @(negedge clk) begin : compare
    ov_t e;
    ov_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.busy = busy;     a.fault = fault;       a.depth = depth;
      a.pcWrite = pcWrite; a.pcSrc = pcSrc;     a.iOrD = iOrD;
      a.memRead = memRead; a.memWrite = memWrite; a.irWrite = irWrite;
      a.mdrWrite = mdrWrite; a.stPush = stPush; a.stPop = stPop;
      a.stSrc = stSrc;   a.aLd = aLd;           a.bLd = bLd;
      a.aluOp = aluOp;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t op=%0d got=%b expected=%b", $time, opcode, a, e);
      end
    end
  end

  initial begin
    int n;
    logic [2:0] op;
    logic z;
    int ra;

    do_reset(2);
    lit("reset_busy", busy, 0);
    lit("reset_depth", depth, 0);

    exec(3'd4, 1'b0, -1, n); lit("push_cycles", n, 4);
    exec(3'd4, 1'b1, -1, n);
    exec(3'd0, 1'b0, -1, n); lit("add_cycles", n, 5);
    exec(3'd7, 1'b1, -1, n); lit("jz_taken_cycles", n, 3);
    lit("depth_after_add", depth, 1);
    exec(3'd7, 1'b0, -1, n); lit("jz_not_taken_cycles", n, 2);
    lit("depth_after_jz", depth, 1);
    exec(3'd5, 1'b0, -1, n); lit("pop_cycles", n, 4);
    exec(3'd5, 1'b0, -1, n); lit("underflow_cycles", n, 3);
    lit("underflow_fault", fault, 1);
    fault_hold(10);
    lit("fault_sticky", fault, 1);
    lit("fault_not_busy", busy, 0);
    do_reset(1);
    lit("fault_cleared", fault, 0);
    idle(3);

    for (int i = 0; i < 8; i++) exec(3'd4, 1'($urandom_range(0, 1)), -1, n);
    exec(3'd4, 1'b0, -1, n); lit("overflow_cycles", n, 3);
    lit("overflow_depth", depth, 8);
    fault_hold(4);
    do_reset(1);

    exec(3'd4, 1'b0, -1, n);
    exec(3'd4, 1'b0, -1, n);
    exec(3'd0, 1'b0, 3, n);
    lit("midreset_depth", depth, 0);
    lit("midreset_busy", busy, 0);
    idle(2);

    for (int k = 0; k < 400; k++) begin
      op = 3'($urandom_range(0, 7));
      z = 1'($urandom_range(0, 1));
      if (faults(op) && $urandom_range(0, 15) != 0) op = (mdepth >= 8) ? 3'd5 : 3'd4;
      ra = ($urandom_range(0, 40) == 0) ? int'($urandom_range(0, 4)) : -1;
      exec(op, z, ra, n);
      if (mfault) begin
        fault_hold(int'($urandom_range(1, 4)));
        do_reset(int'($urandom_range(1, 2)));
      end
      if (midle && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    @(negedge clk);
    #1;
    lit("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
